// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory server: response word layout
// and the address legality check used on the fetch path.
package imem_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ERR_DATA = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } imem_rsp_t;

    // Word-aligned and inside the array.
    function automatic logic addr_ok(input logic [XLEN-1:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[XLEN-1:2]} < depth);
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO; the head entry is presented combinationally from storage and
// reads as all-zero while the buffer is empty.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  imem_rsp_t push_data,
    input  logic      pop,
    output imem_rsp_t head,
    output logic      empty,
    output logic      full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    imem_rsp_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? imem_rsp_t'('0) : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory server: valid/ready fetch requests, fixed-latency read pipeline,
// credit-limited response FIFO, run-time program port. IMEM_SERVER_STATS_EN adds counters.
module imem_server
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned RSP_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            prog_we,
    input  logic [XLEN-1:0] prog_addr,
    input  logic [XLEN-1:0] prog_wdata
`ifdef IMEM_SERVER_STATS_EN
    ,
    output logic [31:0]     stat_req_cnt,
    output logic [31:0]     stat_stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            accept, pop;
    logic [CW-1:0]   credit_q, credit_d;
    imem_rsp_t       rd_rsp;
    logic            pipe_vld_q [LATENCY];
    imem_rsp_t       pipe_rsp_q [LATENCY];
    imem_rsp_t       fifo_head;
    logic            fifo_empty;
    logic            unused_fifo_full;
    logic            unused_prog_lsb;

    // Credits cover in-flight reads plus buffered responses, so the FIFO never overflows.
    assign req_ready = !rst && !prog_we && (credit_q < CREDIT_MAX);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_head.data;
    assign rsp_err   = fifo_head.err;

    assign unused_prog_lsb = ^prog_addr[1:0];

    always_comb begin
        rd_rsp.data = ERR_DATA;
        rd_rsp.err  = 1'b1;
        if (addr_ok(req_addr, DEPTH_WORDS)) begin
            rd_rsp.data = mem[req_addr[AW+1:2]];
            rd_rsp.err  = 1'b0;
        end
    end

    always_comb begin
        credit_d = credit_q;
        case ({accept, pop})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) credit_q <= '0;
        else     credit_q <= credit_d;
    end

    // Writes never share an edge with an accept, so no read/write bypass is needed.
    always_ff @(posedge clk) begin
        if (prog_we && ({2'b00, prog_addr[XLEN-1:2]} < DEPTH_WORDS)) begin
            mem[prog_addr[AW+1:2]] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) pipe_vld_q[i] <= 1'b0;
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_rsp_q[0] <= rd_rsp;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_rsp_q[i] <= pipe_rsp_q[i-1];
            end
        end
    end

    imem_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_vld_q[LATENCY-1]),
        .push_data (pipe_rsp_q[LATENCY-1]),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (unused_fifo_full)
    );

`ifdef IMEM_SERVER_STATS_EN
    logic [31:0] stat_req_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_req_q   <= stat_req_q + 32'(accept);
            stat_stall_q <= stat_stall_q + 32'(req_valid && !req_ready);
        end
    end

    assign stat_req_cnt   = stat_req_q;
    assign stat_stall_cnt = stat_stall_q;
`else
    // No statistics in this build.
`endif

endmodule

// File: tb/tb_imem_server.sv
// Randomized self-checking bench for imem_server against a queue-based reference model.
// Counter checks are compiled in when IMEM_SERVER_STATS_EN is defined.
module tb_imem_server;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned LATENCY     = 1;
    localparam int unsigned RSP_DEPTH   = 2;
    localparam int unsigned AW          = 10;
    localparam int unsigned WIN         = 16;

    logic        clk, rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, prog_we;
    logic [31:0] req_addr, rsp_data, prog_addr, prog_wdata;
`ifdef IMEM_SERVER_STATS_EN
    logic [31:0] stat_req_cnt, stat_stall_cnt;
`endif

    imem_server #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata)
`ifdef IMEM_SERVER_STATS_EN
        ,
        .stat_req_cnt  (stat_req_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory image, queue of outstanding responses in accept order.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned rdy;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [DEPTH_WORDS];
    int unsigned cyc;
    logic        after_rst;
    logic [31:0] m_req, m_stall;
    int          n_vec, n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] ra, input logic rr, input logic pw,
                        input logic [31:0] pa, input logic [31:0] pd, input logic rs,
                        output logic acc);
        logic exp_ready, exp_valid, pop, ok;
        exp_t it;
        @(negedge clk);
        req_valid  = rv;
        req_addr   = ra;
        rsp_ready  = rr;
        prog_we    = pw;
        prog_addr  = pa;
        prog_wdata = pd;
        rst        = rs;
        #1;
        exp_ready = !rs && !pw && (q.size() < RSP_DEPTH);
        exp_valid = (q.size() != 0) && (cyc >= q[0].rdy);
        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("rsp_data", rsp_data, q[0].data);
            check_eq("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end else if (after_rst) begin
            check_eq("rst_rsp_data", rsp_data, 32'h0);
            check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
        end
`ifdef IMEM_SERVER_STATS_EN
        check_eq("stat_req_cnt", stat_req_cnt, m_req);
        check_eq("stat_stall_cnt", stat_stall_cnt, m_stall);
`endif
        acc = rv && exp_ready;
        pop = exp_valid && rr;
        if (rs) begin
            q.delete();
            after_rst = 1'b1;
            m_req     = '0;
            m_stall   = '0;
        end else begin
            after_rst = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                ok      = (ra[1:0] == 2'b00) && ({2'b00, ra[31:2]} < DEPTH_WORDS);
                it.data = ok ? mm[ra[AW+1:2]] : 32'h0;
                it.err  = !ok;
                it.rdy  = cyc + LATENCY + 1;
                q.push_back(it);
            end
            if (pw && ({2'b00, pa[31:2]} < DEPTH_WORDS)) mm[pa[AW+1:2]] = pd;
            m_req   = m_req + 32'(acc);
            m_stall = m_stall + 32'(rv && !exp_ready);
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    endtask

    task automatic prog(input logic [31:0] pa, input logic [31:0] pd);
        logic acc;
        step(1'b0, 32'h0, 1'b1, 1'b1, pa, pd, 1'b0, acc);
    endtask

    task automatic fetch(input logic [31:0] ra, input logic rr);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) step(1'b1, ra, rr, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        check_eq("accept_bound", 32'(acc), 32'h1);
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    endtask

    initial begin
        logic        acc, rv, rr, pw, rs;
        logic [31:0] ra, pa, pd;
        int unsigned sel;
        n_vec = 0; n_err = 0; cyc = 0; after_rst = 1'b1; m_req = '0; m_stall = '0;
        req_valid = 0; req_addr = 0; rsp_ready = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Program the working window.
        prog(32'h0, 32'h0050_0093);
        prog(32'h4, 32'h00A0_0113);
        for (int i = 2; i < WIN; i++) prog(32'(i * 4), $urandom);

        // Back-to-back fetch.
        step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        step(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        idle(3, 1'b1);

        // Backpressure: two accepts, then stall with head held stable.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        fetch(32'h8, 1'b1);
        idle(4, 1'b1);

        // Misaligned and out-of-range, then a good fetch.
        fetch(32'h6, 1'b1);
        fetch(32'h1000, 1'b1);
        fetch(32'h0, 1'b1);
        idle(4, 1'b1);

        // Write blocks the request; the following read sees the new word.
        step(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, acc);
        fetch(32'h10, 1'b1);
        idle(3, 1'b1);
        // A read accepted before a write keeps the old word.
        fetch(32'h14, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 32'hCAFE_F00D, 1'b0, acc);
        idle(3, 1'b1);
        fetch(32'h14, 1'b1);
        idle(3, 1'b1);

        // Reset with responses buffered and in flight.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        do_reset();
        idle(3, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        step(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        idle(4, 1'b1);

        // Counter scenario: five accepts and three write-blocked request cycles.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch(32'(i * 4), 1'b1);
            idle(2, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h1, 1'b0, acc);
        idle(1, 1'b1);
`ifdef IMEM_SERVER_STATS_EN
        check_eq("stat_req_five", stat_req_cnt, 32'd5);
        check_eq("stat_stall_three", stat_stall_cnt, 32'd3);
        do_reset();
        idle(1, 1'b1);
        check_eq("stat_req_clr", stat_req_cnt, 32'd0);
        check_eq("stat_stall_clr", stat_stall_cnt, 32'd0);
`endif

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            rv  = ($urandom_range(3) != 0);
            sel = $urandom_range(9);
            ra  = {26'h0, 4'($urandom_range(WIN - 1)), 2'b00};
            if (sel == 8) ra[1:0] = 2'($urandom_range(3, 1));
            if (sel == 9) ra = ($urandom_range(1) != 0) ? 32'h1000 + ra : 32'hFFFF_FFFC;
            rr  = ($urandom_range(9) < 7);
            rs  = ($urandom_range(99) == 0);
            pw  = !rs && ($urandom_range(9) == 0);
            pa  = {26'h0, 4'($urandom_range(WIN - 1)), 2'($urandom_range(3))};
            if ($urandom_range(4) == 0) pa = pa + 32'h1000;
            pd  = $urandom;
            step(rv, ra, rr, pw, pa, pd, rs, acc);
        end
        idle(6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
